// File: rtl/regfile_pc.sv
// Register file of 2**ADDR n-bit registers; the top index is a PC that can self-increment.
// Two combinational read ports with optional write-to-read forwarding.
module regfile_pc #(
    parameter int n      = 16,
    parameter int ADDR   = 3,
    parameter int BYPASS = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [n-1:0]    in,
    input  logic            WE,
    input  logic [ADDR-1:0] waddr,
    input  logic            incr_pc,
    input  logic [ADDR-1:0] raddrA,
    input  logic [ADDR-1:0] raddrB,
    output logic [n-1:0]    outA,
    output logic [n-1:0]    outB,
    output logic [n-1:0]    pc
);

    localparam int              NREG   = 2 ** ADDR;
    localparam logic [ADDR-1:0] PC_IDX = '1;
    localparam logic [n-1:0]    ONE    = {{(n-1){1'b0}}, 1'b1};

    logic [n-1:0] r_regs [NREG];
    logic         w_pc_wr;

    // An explicit write to the PC overrides a same-cycle increment.
    assign w_pc_wr = WE && (waddr == PC_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            if (WE) r_regs[waddr] <= in;
            if (incr_pc && !w_pc_wr) r_regs[PC_IDX] <= r_regs[PC_IDX] + ONE;
        end
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            // Only the write data is forwarded; the incremented PC never is.
            assign outA = (WE && (raddrA == waddr)) ? in : r_regs[raddrA];
            assign outB = (WE && (raddrB == waddr)) ? in : r_regs[raddrB];
        end else begin : g_nobypass
            assign outA = r_regs[raddrA];
            assign outB = r_regs[raddrB];
        end
    endgenerate

    assign pc = r_regs[PC_IDX];

endmodule

// File: tb/tb_regfile_pc.sv
// Directed bench driving a BYPASS=0 and a BYPASS=1 instance from the same stimulus.
// Each vector's expected outputs are the values visible before the clock edge it is applied on.
module tb_regfile_pc;

    logic        clk = 1'b0;
    logic        reset, WE, incr_pc;
    logic [15:0] din;
    logic [2:0]  waddr, raddrA, raddrB;
    logic [15:0] outA0, outB0, pc0, outA1, outB1, pc1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_pc #(.n(16), .ADDR(3), .BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .in(din), .WE(WE), .waddr(waddr), .incr_pc(incr_pc),
        .raddrA(raddrA), .raddrB(raddrB), .outA(outA0), .outB(outB0), .pc(pc0)
    );

    regfile_pc #(.n(16), .ADDR(3), .BYPASS(1)) u_bp (
        .clk(clk), .reset(reset), .in(din), .WE(WE), .waddr(waddr), .incr_pc(incr_pc),
        .raddrA(raddrA), .raddrB(raddrB), .outA(outA1), .outB(outB1), .pc(pc1)
    );

    typedef struct {
        logic        rst, we, inc, chk;
        logic [2:0]  wa, ra, rb;
        logic [15:0] din;
        logic [15:0] a0, a1, b0, b1, p;
    } vec_t;

    vec_t tv[22];

    function automatic vec_t mk(logic rst, logic we, logic [2:0] wa, logic [15:0] d, logic inc,
                                logic [2:0] ra, logic [2:0] rb, logic chk,
                                logic [15:0] a0, logic [15:0] a1, logic [15:0] b0,
                                logic [15:0] b1, logic [15:0] p);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.din = d; v.inc = inc; v.ra = ra; v.rb = rb;
        v.chk = chk; v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1; v.p = p;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; WE = v.we; waddr = v.wa; din = v.din; incr_pc = v.inc;
        raddrA = v.ra; raddrB = v.rb;
    endtask

    initial begin
        //            rst we wa din      inc ra rb chk a0       a1       b0       b1       pc
        tv[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 7, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tv[1]  = mk(1, 0, 0, 16'h0000, 0, 0, 7, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tv[2]  = mk(0, 1, 3, 16'h1010, 0, 3, 0, 1, 16'h0000, 16'h1010, 16'h0000, 16'h0000, 16'h0000);
        tv[3]  = mk(0, 0, 0, 16'h0000, 0, 3, 1, 1, 16'h1010, 16'h1010, 16'h0000, 16'h0000, 16'h0000);
        tv[4]  = mk(0, 0, 0, 16'h0000, 0, 2, 4, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tv[5]  = mk(0, 1, 7, 16'hFFFE, 0, 7, 7, 1, 16'h0000, 16'hFFFE, 16'h0000, 16'hFFFE, 16'h0000);
        tv[6]  = mk(0, 0, 0, 16'h0000, 1, 7, 0, 1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h0000, 16'hFFFE);
        tv[7]  = mk(0, 0, 0, 16'h0000, 1, 7, 0, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF);
        tv[8]  = mk(0, 0, 0, 16'h0000, 1, 7, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tv[9]  = mk(0, 1, 7, 16'h0005, 0, 7, 3, 1, 16'h0001, 16'h0005, 16'h1010, 16'h1010, 16'h0001);
        tv[10] = mk(0, 1, 7, 16'h0040, 1, 6, 7, 1, 16'h0000, 16'h0000, 16'h0005, 16'h0040, 16'h0005);
        tv[11] = mk(0, 1, 2, 16'h00AA, 1, 7, 2, 1, 16'h0040, 16'h0040, 16'h0000, 16'h00AA, 16'h0040);
        tv[12] = mk(0, 1, 2, 16'h0055, 0, 2, 2, 1, 16'h00AA, 16'h0055, 16'h00AA, 16'h0055, 16'h0041);
        tv[13] = mk(0, 0, 0, 16'h0000, 0, 2, 7, 1, 16'h0055, 16'h0055, 16'h0041, 16'h0041, 16'h0041);
        tv[14] = mk(0, 1, 1, 16'h1234, 0, 1, 0, 1, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0041);
        tv[15] = mk(0, 1, 7, 16'h0010, 0, 1, 7, 1, 16'h1234, 16'h1234, 16'h0041, 16'h0010, 16'h0041);
        tv[16] = mk(1, 1, 1, 16'h0011, 1, 1, 7, 1, 16'h1234, 16'h0011, 16'h0010, 16'h0010, 16'h0010);
        tv[17] = mk(1, 0, 0, 16'h0000, 0, 1, 2, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tv[18] = mk(0, 0, 0, 16'h0011, 0, 0, 3, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tv[19] = mk(0, 0, 0, 16'h0011, 0, 0, 3, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tv[20] = mk(0, 1, 0, 16'h0011, 1, 0, 0, 1, 16'h0000, 16'h0011, 16'h0000, 16'h0011, 16'h0000);
        tv[21] = mk(0, 0, 0, 16'h0000, 0, 0, 7, 1, 16'h0011, 16'h0011, 16'h0001, 16'h0001, 16'h0001);

        drive(tv[0]);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            if (tv[i].chk) begin
                check("outA_nb", i, outA0, tv[i].a0);
                check("outA_bp", i, outA1, tv[i].a1);
                check("outB_nb", i, outB0, tv[i].b0);
                check("outB_bp", i, outB1, tv[i].b1);
                check("pc_nb",   i, pc0,   tv[i].p);
                check("pc_bp",   i, pc1,   tv[i].p);
            end
        end

        // Reset held with a write pending: forwarding still visible, storage stays clear.
        @(negedge clk);
        reset = 1'b1; WE = 1'b1; waddr = 3'd5; din = 16'hABCD; incr_pc = 1'b0;
        raddrA = 3'd5; raddrB = 3'd0;
        #1;
        check("rst_fwd_nb", 0, outA0, 16'h0000);
        check("rst_fwd_bp", 0, outA1, 16'hABCD);
        @(negedge clk);
        WE = 1'b0;
        #1;
        check("rst_hold_nb", 0, outA0, 16'h0000);
        check("rst_hold_bp", 0, outA1, 16'h0000);
        check("rst_pc",      0, pc1,   16'h0000);

        // First edge after release increments immediately.
        @(negedge clk);
        reset = 1'b0; incr_pc = 1'b1;
        @(negedge clk);
        incr_pc = 1'b0;
        #1;
        check("resume_pc_nb", 0, pc0, 16'h0001);
        check("resume_pc_bp", 0, pc1, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_pc.md
REGFILE_PC -- requirements
Module: regfile_pc

Interface
REQ-001 SHALL have parameter n, default 16, meaning data width of every register in bits.
REQ-002 SHALL have parameter ADDR, default 3, meaning address width; register count is 2**ADDR, indices 0..2**ADDR-1.
REQ-003 SHALL have parameter BYPASS, default 0, meaning 1 enables write-to-read forwarding on both read ports.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in  input  n  write data.
REQ-007 SHALL have port WE  input  1  write enable for the register selected by waddr.
REQ-008 SHALL have port waddr  input  ADDR  write register index.
REQ-009 SHALL have port incr_pc  input  1  increment request for the PC register.
REQ-010 SHALL have port raddrA  input  ADDR  read port A index.
REQ-011 SHALL have port raddrB  input  ADDR  read port B index.
REQ-012 SHALL have port outA  output  n  read port A data.
REQ-013 SHALL have port outB  output  n  read port B data.
REQ-014 SHALL have port pc  output  n  current PC register value, always driven.

Function
REQ-015 SHALL hold 2**ADDR registers of n bits; the PC register is index 2**ADDR-1 (R7 at default).
REQ-016 SHALL update registers only on rising clk edge; no other edge or level changes state.
REQ-017 SHALL, when WE=1 and reset=0, load in into register waddr at the edge; all other non-PC registers hold.
REQ-018 SHALL, when incr_pc=1, WE=0 or waddr != PC index, and reset=0, load PC+1 into PC at the edge.
REQ-019 SHALL compute PC+1 modulo 2**n; all-ones wraps to zero, no carry out, no flag.
REQ-020 SHALL, when WE=1 with waddr = PC index and incr_pc=1 in the same cycle, load in into PC; write wins, increment discarded.
REQ-021 SHALL, with WE=0 and incr_pc=0, hold all registers unchanged.
REQ-022 SHALL drive outA/outB combinationally from registers raddrA/raddrB; zero-cycle read latency.
REQ-023 SHALL allow raddrA = raddrB = any index; both ports return the same value.
REQ-024 SHALL, when BYPASS=0, return the pre-edge stored value when reading the address being written in that cycle; new value visible after the edge.
REQ-025 SHALL, when BYPASS=1, WE=1 and raddrX = waddr, drive outX = in in the same cycle (per port, independently).
REQ-026 SHALL not forward incremented PC through the bypass; reads of PC index show stored PC unless REQ-025 applies.
REQ-027 SHALL drive pc from the stored PC register only, never bypassed.
REQ-028 SHALL contain no latches and no combinational loops.

Reset
REQ-029 SHALL, when reset=1 at a rising edge, clear every register, including PC, to zero.
REQ-030 SHALL give reset priority over WE and incr_pc in the same cycle; the write and increment are lost.
REQ-031 SHALL, with reset asserted, show outA = outB = pc = 0 after the first edge; BYPASS forwarding still applies combinationally when WE=1.
REQ-032 SHALL resume normal operation at the first edge with reset=0; no extra recovery cycles.
REQ-033 SHALL define no register value before the first reset edge; the bench SHALL apply reset first.

Verification
REQ-034 SHALL cover write then read: reset; WE=1 waddr=3 in=16'h1010; next cycle WE=0 raddrA=3 -> outA=16'h1010, other registers 0.
REQ-035 SHALL cover PC increment and wrap: write PC=16'hFFFE; incr_pc=1 for 3 cycles -> pc = 16'hFFFF, 16'h0000, 16'h0001.
REQ-036 SHALL cover write/increment collision: pc=16'h0005; WE=1 waddr=7 in=16'h0040 incr_pc=1 -> pc=16'h0040 after edge.
REQ-037 SHALL cover bypass: BYPASS=0 and BYPASS=1 builds; R2=16'h00AA; WE=1 waddr=2 in=16'h0055 raddrA=2 -> before edge outA=16'h00AA (BYPASS=0) / 16'h0055 (BYPASS=1); after edge 16'h0055 both.
REQ-038 SHALL cover reset mid-operation: load R1=16'h1234, pc=16'h0010; assert reset with WE=1 waddr=1 in=16'h0011 incr_pc=1 -> after edge R1=0, pc=0.
REQ-039 SHALL cover WE=0 hold: WE=0 in=16'h0011 waddr=0 for 2 cycles -> R0 stays 0; then WE=1 -> R0=16'h0011.
